// File: rtl/uart_pkg.sv
// Shared defaults and drain-FSM encoding for the UART receive FIFO.
package uart_pkg;

    localparam int DWL_DEF   = 8;
    localparam int DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_DONE = 2'd2
    } drain_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: DEPTH x DWL register array, synchronous write, asynchronous read.
module uart_fifo_mem #(
    parameter int DWL   = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           CLK,
    input  logic           we_i,
    input  logic [AW-1:0]  waddr_i,
    input  logic [DWL-1:0] wdata_i,
    input  logic [AW-1:0]  raddr_i,
    output logic [DWL-1:0] rdata_o
);

    logic [DWL-1:0] mem_q [DEPTH];

    // Storage is deliberately left unreset; occupancy is tracked by the pointers.
    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between a UART receiver and transmitter, with a drain FSM
// that hands bytes to the transmitter one at a time.
//
// state        | meaning
// ST_IDLE      | waiting for a stored byte and an idle transmitter
// ST_LOAD      | TX_WE high, TX_DATA held until the transmitter reports busy
// ST_WAIT_DONE | byte popped, waiting for the transmitter to finish
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DWL   = DWL_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     WR_STB,
    input  logic [DWL-1:0]           WR_DATA,
    input  logic                     TX_BUSY,
    output logic                     TX_WE,
    output logic [DWL-1:0]           TX_DATA,
    input  logic                     CLR_OVR,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERRUN
);

    localparam int AW = $clog2(DEPTH);

    drain_state_e   state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           ovr_q, ovr_d;
    logic [DWL-1:0] tx_data_q, tx_data_d;
    logic [DWL-1:0] rd_data;
    logic           full, empty, pop, wr_en;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign pop   = (state_q == ST_LOAD) && TX_BUSY;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign wr_en = WR_STB && (!full || pop);

    uart_fifo_mem #(
        .DWL   (DWL),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .CLK     (CLK),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (WR_DATA),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty && !TX_BUSY) begin
                    state_d   = ST_LOAD;
                    tx_data_d = rd_data;
                end
            end
            ST_LOAD: begin
                if (TX_BUSY) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!TX_BUSY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        ovr_d = ovr_q;
        if (WR_STB && full && !pop) begin
            ovr_d = 1'b1;
        end else if (CLR_OVR) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovr_q     <= 1'b0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovr_q     <= ovr_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign TX_WE   = (state_q == ST_LOAD);
    assign TX_DATA = tx_data_q;
    assign FULL    = full;
    assign EMPTY   = empty;
    assign COUNT   = count_q;
    assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DWL=8, DEPTH=16).
module tb_uart_rx_fifo;

    logic       CLK = 1'b0;
    logic       RST;
    logic       WR_STB;
    logic [7:0] WR_DATA;
    logic       TX_BUSY;
    logic       TX_WE;
    logic [7:0] TX_DATA;
    logic       CLR_OVR;
    logic       FULL;
    logic       EMPTY;
    logic [4:0] COUNT;
    logic       OVERRUN;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo dut (
        .CLK     (CLK),
        .RST     (RST),
        .WR_STB  (WR_STB),
        .WR_DATA (WR_DATA),
        .TX_BUSY (TX_BUSY),
        .TX_WE   (TX_WE),
        .TX_DATA (TX_DATA),
        .CLR_OVR (CLR_OVR),
        .FULL    (FULL),
        .EMPTY   (EMPTY),
        .COUNT   (COUNT),
        .OVERRUN (OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        WR_STB  = 1'b1;
        WR_DATA = d;
        tick();
        WR_STB  = 1'b0;
    endtask

    // Transmitter model: wait for TX_WE, take the byte, stay busy for busy_cyc cycles.
    task automatic get_byte(output logic [7:0] d, input int busy_cyc);
        int k = 0;
        while (!TX_WE && k < 64) begin
            tick();
            k++;
        end
        chk("we_timeout", 32'(TX_WE), 32'd1);
        d = TX_DATA;
        TX_BUSY = 1'b1;
        tick();
        for (int i = 1; i < busy_cyc; i++) tick();
        TX_BUSY = 1'b0;
        tick();
    endtask

    task automatic no_we(input string tag, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (TX_WE) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [7:0] b;

        RST = 1'b1; WR_STB = 1'b0; WR_DATA = '0; TX_BUSY = 1'b0; CLR_OVR = 1'b0;
        tick();
        tick();
        chk("rst_count",   32'(COUNT),   32'd0);
        chk("rst_empty",   32'(EMPTY),   32'd1);
        chk("rst_full",    32'(FULL),    32'd0);
        chk("rst_ovr",     32'(OVERRUN), 32'd0);
        chk("rst_we",      32'(TX_WE),   32'd0);
        chk("rst_txdata",  32'(TX_DATA), 32'd0);
        RST = 1'b0;
        tick();

        // Single byte and latency
        push(8'hA5);
        chk("single_we_n1",    32'(TX_WE), 32'd0);
        chk("single_count_n1", 32'(COUNT), 32'd1);
        tick();
        chk("single_we_n2",    32'(TX_WE),   32'd1);
        chk("single_data",     32'(TX_DATA), 32'hA5);
        tick();
        chk("single_we_hold",  32'(TX_WE),   32'd1);
        chk("single_data_hold", 32'(TX_DATA), 32'hA5);
        TX_BUSY = 1'b1;
        tick();
        chk("single_we_drop",  32'(TX_WE), 32'd0);
        chk("single_count0",   32'(COUNT), 32'd0);
        chk("single_empty",    32'(EMPTY), 32'd1);
        TX_BUSY = 1'b0;
        tick();
        chk("single_data_keep", 32'(TX_DATA), 32'hA5);
        no_we("single_no_repeat", 5);

        // Ordering with a slow transmitter
        push(8'h01);
        push(8'h02);
        push(8'h03);
        for (int i = 1; i <= 3; i++) begin
            get_byte(b, 10);
            chk("order_byte", 32'(b), 32'(i));
        end
        chk("order_empty", 32'(EMPTY), 32'd1);
        no_we("order_no_repeat", 8);

        // Full and overrun
        TX_BUSY = 1'b1;
        for (int i = 0; i < 17; i++) push(8'(8'h10 + i));
        chk("full_flag",   32'(FULL),    32'd1);
        chk("full_count",  32'(COUNT),   32'd16);
        chk("full_ovr",    32'(OVERRUN), 32'd1);
        chk("full_we",     32'(TX_WE),   32'd0);
        TX_BUSY = 1'b0;
        for (int i = 0; i < 16; i++) begin
            get_byte(b, 2);
            chk("drain_byte", 32'(b), 32'(8'h10 + i));
        end
        no_we("drain_17th_absent", 6);
        chk("drain_empty",    32'(EMPTY),   32'd1);
        chk("drain_ovr_kept", 32'(OVERRUN), 32'd1);
        CLR_OVR = 1'b1;
        tick();
        CLR_OVR = 1'b0;
        chk("clr_ovr", 32'(OVERRUN), 32'd0);

        // Write coinciding with pop while full
        TX_BUSY = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
        TX_BUSY = 1'b0;
        tick();
        chk("simul_load_we",   32'(TX_WE),   32'd1);
        chk("simul_load_data", 32'(TX_DATA), 32'h30);
        WR_STB = 1'b1; WR_DATA = 8'h40; TX_BUSY = 1'b1;
        tick();
        WR_STB = 1'b0;
        chk("simul_count", 32'(COUNT),   32'd16);
        chk("simul_ovr",   32'(OVERRUN), 32'd0);
        chk("simul_full",  32'(FULL),    32'd1);
        chk("simul_we",    32'(TX_WE),   32'd0);
        WR_STB = 1'b1; WR_DATA = 8'h41; CLR_OVR = 1'b1;
        tick();
        WR_STB = 1'b0; CLR_OVR = 1'b0;
        chk("ovr_priority", 32'(OVERRUN), 32'd1);
        CLR_OVR = 1'b1;
        tick();
        CLR_OVR = 1'b0;
        chk("ovr_clear2", 32'(OVERRUN), 32'd0);
        TX_BUSY = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            get_byte(b, 2);
            chk("simul_drain", 32'(b), 32'(8'h31 + i));
        end
        no_we("simul_no_0x41", 6);

        // Pointer wrap across 40 bytes
        for (int bt = 0; bt < 5; bt++) begin
            for (int j = 0; j < 8; j++) push(8'(bt * 8 + j));
            for (int j = 0; j < 8; j++) begin
                get_byte(b, 1);
                chk("wrap_byte", 32'(b), 32'(bt * 8 + j));
            end
        end
        chk("wrap_empty", 32'(EMPTY), 32'd1);

        // Reset in the middle of a load
        TX_BUSY = 1'b1;
        for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
        TX_BUSY = 1'b0;
        tick();
        chk("mid_pre_we",    32'(TX_WE), 32'd1);
        chk("mid_pre_count", 32'(COUNT), 32'd5);
        RST = 1'b1;
        #1;
        chk("mid_rst_we",    32'(TX_WE), 32'd0);
        chk("mid_rst_count", 32'(COUNT), 32'd0);
        chk("mid_rst_empty", 32'(EMPTY), 32'd1);
        @(negedge CLK);
        RST = 1'b0;
        no_we("mid_no_we", 10);
        push(8'h77);
        get_byte(b, 3);
        chk("post_rst_byte", 32'(b), 32'h77);
        chk("post_rst_empty", 32'(EMPTY), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
